// File: rtl/audio_voice_scheduler_if.sv
// Voice producer handshakes and DAC sample bus of the two-voice audio scheduler.
interface audio_voice_scheduler_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] v0_data;
   logic                    v0_valid;
   logic                    v0_ready;
   logic signed [WIDTH-1:0] v1_data;
   logic                    v1_valid;
   logic                    v1_ready;
   logic signed [WIDTH-1:0] sample_out;
   logic                    sample_stb;

   modport slave (
      input  v0_data, v0_valid, v1_data, v1_valid,
      output v0_ready, v1_ready, sample_out, sample_stb
   );

   modport master (
      output v0_data, v0_valid, v1_data, v1_valid,
      input  v0_ready, v1_ready, sample_out, sample_stb
   );
endinterface

// File: rtl/audio_voice_scheduler.sv
// Two-voice sample scheduler: sample-rate tick, per-voice holding registers,
// two-stage mix/attenuate/saturate pipeline feeding the sigma-delta DAC.
module audio_voice_scheduler #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 1125,
   parameter int UCNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [3:0]           volume,
   input  logic                 clr_underrun,
   output logic [UCNT_W-1:0]    underrun_cnt,
   audio_voice_scheduler_if.slave bus
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic signed [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH:0] SAT_MIN = {2'b11, {(WIDTH-1){1'b0}}};

   typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_e;

   state_e                   state_q, state_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic [1:0]               full_q, full_d;
   logic [1:0][WIDTH-1:0]    hold_q, hold_d;
   logic [1:0][WIDTH-1:0]    cap_q, cap_d;
   logic [1:0]               vld_pipe_q, vld_pipe_d;
   logic [WIDTH-1:0]         out_q, out_d;
   logic [UCNT_W-1:0]        ucnt_q, ucnt_d;

   logic                     run, tick;
   logic [1:0]               vld, rdy;
   logic [1:0][WIDTH-1:0]    din;
   logic [1:0]               inc;
   logic [UCNT_W:0]          ucnt_sum;
   logic signed [WIDTH:0]    sum, shifted;
   logic [WIDTH-1:0]         mix;

   assign din  = {bus.v1_data, bus.v0_data};
   assign vld  = {bus.v1_valid, bus.v0_valid};
   assign run  = (state_q == RUN);
   assign tick = run && (div_q == DIV_MAX);
   assign rdy  = {2{run}} & ~full_q;

   // Mix at one extra bit so the sum of two full-scale voices cannot wrap.
   always_comb begin
      sum     = $signed({cap_q[0][WIDTH-1], cap_q[0]}) + $signed({cap_q[1][WIDTH-1], cap_q[1]});
      shifted = sum >>> volume;
      if (shifted > SAT_MAX)      mix = SAT_MAX[WIDTH-1:0];
      else if (shifted < SAT_MIN) mix = SAT_MIN[WIDTH-1:0];
      else                        mix = shifted[WIDTH-1:0];
   end

   always_comb begin
      inc      = {1'b0, ~full_q[0]} + {1'b0, ~full_q[1]};
      ucnt_sum = {1'b0, ucnt_q} + {{(UCNT_W-1){1'b0}}, inc};
   end

   always_comb begin
      state_d    = enable ? RUN : OFF;
      div_d      = div_q;
      full_d     = full_q;
      hold_d     = hold_q;
      cap_d      = cap_q;
      vld_pipe_d = vld_pipe_q;
      out_d      = out_q;
      ucnt_d     = ucnt_q;

      if (clr_underrun)         ucnt_d = '0;
      else if (tick && enable)  ucnt_d = ucnt_sum[UCNT_W] ? '1 : ucnt_sum[UCNT_W-1:0];

      if (!enable || !run) begin
         // Leaving or outside RUN: drop everything so a restart sees no stale samples.
         div_d      = '0;
         full_d     = '0;
         cap_d      = '0;
         vld_pipe_d = '0;
         out_d      = '0;
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         for (int i = 0; i < 2; i++) begin
            // An empty voice handshaking on the tick edge is kept for the next slot.
            if (vld[i] && rdy[i]) begin
               full_d[i] = 1'b1;
               hold_d[i] = din[i];
            end else if (tick) begin
               full_d[i] = 1'b0;
            end
            if (tick) cap_d[i] = full_q[i] ? hold_q[i] : '0;
         end
         vld_pipe_d = {vld_pipe_q[0], tick};
         if (vld_pipe_q[0]) out_d = mix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OFF;
         div_q      <= '0;
         full_q     <= '0;
         hold_q     <= '0;
         cap_q      <= '0;
         vld_pipe_q <= '0;
         out_q      <= '0;
         ucnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         full_q     <= full_d;
         hold_q     <= hold_d;
         cap_q      <= cap_d;
         vld_pipe_q <= vld_pipe_d;
         out_q      <= out_d;
         ucnt_q     <= ucnt_d;
      end
   end

   assign bus.v0_ready   = rdy[0];
   assign bus.v1_ready   = rdy[1];
   assign bus.sample_out = out_q;
   assign bus.sample_stb = vld_pipe_q[1];
   assign underrun_cnt   = ucnt_q;
endmodule
